// File: rtl/dmem_io_pkg.sv
// Shared constants for the data-memory / MMIO block: RAM geometry, register
// addresses, timer control bit positions and the address decoder.
package dmem_io_pkg;

  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW    = 8;

  localparam logic [31:0] ADDR_LED   = 32'h0000_7F00;
  localparam logic [31:0] ADDR_SW    = 32'h0000_7F04;
  localparam logic [31:0] ADDR_TCNT  = 32'h0000_7F08;
  localparam logic [31:0] ADDR_TCMP  = 32'h0000_7F0C;
  localparam logic [31:0] ADDR_TCTRL = 32'h0000_7F10;
  localparam logic [31:0] ADDR_TSTAT = 32'h0000_7F14;

  localparam int TCTRL_EN     = 0;
  localparam int TCTRL_RELOAD = 1;
  localparam int TCTRL_IRQ_EN = 2;
  localparam int TCTRL_W      = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCNT,
    SEL_TCMP,
    SEL_TCTRL,
    SEL_TSTAT
  } sel_e;

  // Decodes the word address (byte address bits [31:2]) into a target.
  function automatic sel_e decode(input logic [29:0] word_addr);
    sel_e sel;
    sel = SEL_NONE;
    if (word_addr[29:RAM_AW] == '0)           sel = SEL_RAM;
    else if (word_addr == ADDR_LED[31:2])     sel = SEL_LED;
    else if (word_addr == ADDR_SW[31:2])      sel = SEL_SW;
    else if (word_addr == ADDR_TCNT[31:2])    sel = SEL_TCNT;
    else if (word_addr == ADDR_TCMP[31:2])    sel = SEL_TCMP;
    else if (word_addr == ADDR_TCTRL[31:2])   sel = SEL_TCTRL;
    else if (word_addr == ADDR_TSTAT[31:2])   sel = SEL_TSTAT;
    return sel;
  endfunction

endpackage

// File: rtl/io_timer.sv
// Free-running compare timer with optional auto-reload and a sticky
// write-1-to-clear match flag that drives the interrupt level.
module io_timer
  import dmem_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tcnt_we,
  input  logic        tcmp_we,
  input  logic        tctrl_we,
  input  logic        tstat_we,
  input  logic [31:0] wdata,
  output logic [31:0] tcnt,
  output logic [31:0] tcmp,
  output logic [31:0] tctrl,
  output logic [31:0] tstat,
  output logic        irq
);

  logic [31:0]        tcnt_reg;
  logic [31:0]        tcnt_next;
  logic [31:0]        tcmp_reg;
  logic [TCTRL_W-1:0] tctrl_reg;
  logic               tstat_reg;
  logic               tstat_next;
  logic               enable;
  logic               match;

  assign enable = tctrl_reg[TCTRL_EN];
  assign match  = enable && (tcnt_reg == tcmp_reg);

  always_comb begin
    tcnt_next = tcnt_reg;
    if (tcnt_we) begin
      tcnt_next = wdata;
    end else if (enable) begin
      if (match && tctrl_reg[TCTRL_RELOAD]) tcnt_next = '0;
      else                                  tcnt_next = tcnt_reg + 32'd1;
    end
  end

  // Clear is applied first so that a match in the same cycle wins.
  always_comb begin
    tstat_next = tstat_reg;
    if (tstat_we && wdata[0]) tstat_next = 1'b0;
    if (match)                tstat_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_reg  <= '0;
      tcmp_reg  <= '0;
      tctrl_reg <= '0;
      tstat_reg <= 1'b0;
    end else begin
      tcnt_reg  <= tcnt_next;
      tstat_reg <= tstat_next;
      if (tcmp_we)  tcmp_reg  <= wdata;
      if (tctrl_we) tctrl_reg <= wdata[TCTRL_W-1:0];
    end
  end

  assign tcnt  = tcnt_reg;
  assign tcmp  = tcmp_reg;
  assign tctrl = {{(32-TCTRL_W){1'b0}}, tctrl_reg};
  assign tstat = {31'b0, tstat_reg};
  assign irq   = tstat_reg & tctrl_reg[TCTRL_IRQ_EN];

endmodule

// File: rtl/dmem_io.sv
// CPU data memory with memory-mapped LEDs, switches and timer. Loads are
// combinational; stores commit on the rising edge.
module dmem_io
  import dmem_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led,
  output logic        timer_irq,
  input  logic [7:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  logic [31:0] ram [RAM_DEPTH];
  logic [31:0] led_reg;
  logic [15:0] sw_meta_reg;
  logic [15:0] sw_sync_reg;
  sel_e        sel;
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic [31:0] tctrl;
  logic [31:0] tstat;
  logic        unused_byte_lane;

  assign unused_byte_lane = ^addr[1:0];
  assign sel = decode(addr[31:2]);

  // RAM has no reset path, so a store coincident with rst still lands.
  always_ff @(posedge clk) begin
    if (MemWrite && sel == SEL_RAM) ram[addr[RAM_AW+1:2]] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg     <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw_in;
      sw_sync_reg <= sw_meta_reg;
      if (MemWrite && sel == SEL_LED) led_reg <= writedata;
    end
  end

  io_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .tcnt_we  (MemWrite && sel == SEL_TCNT),
    .tcmp_we  (MemWrite && sel == SEL_TCMP),
    .tctrl_we (MemWrite && sel == SEL_TCTRL),
    .tstat_we (MemWrite && sel == SEL_TSTAT),
    .wdata    (writedata),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .tctrl    (tctrl),
    .tstat    (tstat),
    .irq      (timer_irq)
  );

  always_comb begin
    readdata = '0;
    unique case (sel)
      SEL_RAM:   readdata = ram[addr[RAM_AW+1:2]];
      SEL_LED:   readdata = led_reg;
      SEL_SW:    readdata = {16'b0, sw_sync_reg};
      SEL_TCNT:  readdata = tcnt;
      SEL_TCMP:  readdata = tcmp;
      SEL_TCTRL: readdata = tctrl;
      SEL_TSTAT: readdata = tstat;
      default:   readdata = '0;
    endcase
  end

  assign led      = led_reg[15:0];
  assign dbg_data = ram[dbg_sel];

endmodule
